// File: rtl/icache_direct_pkg.sv
// icache_direct shared types and defaults.
// Optional hit/miss counters: ICACHE_PERF_CNT_EN.
package icache_direct_pkg;

  localparam int ICACHE_ADDR_WIDTH = 32;
  localparam int ICACHE_DATA_WIDTH = 32;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_NUM_LINES  = 16;

  typedef enum logic [1:0] {
    ICACHE_IDLE   = 2'd0,
    ICACHE_LOOKUP = 2'd1,
    ICACHE_REFILL = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and pmem-side bundle of icache_direct.
// slave = cache view, master = core/pmem view.
interface icache_direct_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  ifu_req_valid_i;
  logic                  ifu_req_ready_o;
  logic [ADDR_WIDTH-1:0] ifu_addr_i;
  logic                  ifu_resp_valid_o;
  logic [DATA_WIDTH-1:0] ifu_instr_o;
  logic                  fence_i_i;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_resp_valid_i;
  logic [DATA_WIDTH-1:0] mem_resp_data_i;

  modport slave (
    input  ifu_req_valid_i,
    input  ifu_addr_i,
    input  fence_i_i,
    input  mem_req_ready_i,
    input  mem_resp_valid_i,
    input  mem_resp_data_i,
    output ifu_req_ready_o,
    output ifu_resp_valid_o,
    output ifu_instr_o,
    output mem_req_valid_o,
    output mem_addr_o
  );

  modport master (
    output ifu_req_valid_i,
    output ifu_addr_i,
    output fence_i_i,
    output mem_req_ready_i,
    output mem_resp_valid_i,
    output mem_resp_data_i,
    input  ifu_req_ready_o,
    input  ifu_resp_valid_o,
    input  ifu_instr_o,
    input  mem_req_valid_o,
    input  mem_addr_o
  );

endinterface

// File: rtl/icache_data_array.sv
// Flop-based line storage for icache_direct.
// Async read, one write port; no reset on contents.
module icache_data_array #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [$clog2(NUM_LINES)-1:0]  i_wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] i_wr_word,
  input  logic [DATA_WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(NUM_LINES)-1:0]  i_rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] i_rd_word,
  output logic [DATA_WIDTH-1:0]         o_rd_data
);

  localparam int DEPTH = NUM_LINES * LINE_WORDS;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // store one refill beat
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[{i_wr_idx, i_wr_word}] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[{i_rd_idx, i_rd_word}];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache, npc <-> pmem.
// Define ICACHE_PERF_CNT_EN for hit/miss counters.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int NUM_LINES  = ICACHE_NUM_LINES
) (
  input  logic               clk,
  input  logic               rst_n,
  icache_direct_if.slave     bus,
  output logic [31:0]        perf_hit_cnt_o,
  output logic [31:0]        perf_miss_cnt_o
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT =
    OFF_W'(LINE_WORDS - 1);

  icache_state_e         r_state;
  logic [ADDR_WIDTH-3:0] r_addr;
  logic [OFF_W-1:0]      r_beat;
  logic                  r_wait;
  logic                  r_flush;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [NUM_LINES-1:0]  r_valid;
  logic [TAG_W-1:0]      r_tag [NUM_LINES];

  logic [OFF_W-1:0]      w_off;
  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_lookup;
  logic                  w_lk_hit;
  logic                  w_resp;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_beat_req;
  logic                  w_beat_fire;
  logic                  w_beat_done;
  logic                  w_last;
  logic                  w_fill_done;
  logic                  w_flush_now;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused_lo;

  // byte offset inside a word is irrelevant for fetch
  assign w_unused_lo = ^bus.ifu_addr_i[1:0];

  assign w_off = r_addr[OFF_W-1:0];
  assign w_idx = r_addr[OFF_W +: IDX_W];
  assign w_tag = r_addr[ADDR_WIDTH-3 -: TAG_W];

  assign w_hit = r_valid[w_idx]
              && (r_tag[w_idx] == w_tag);

  assign w_lookup = (r_state == ICACHE_LOOKUP);
  assign w_lk_hit = w_lookup && w_hit;
  assign w_resp   = rst_n && w_lk_hit;

  // a pending flush blocks new work until IDLE applies it
  assign w_ready  = rst_n && !r_flush
                 && ((r_state == ICACHE_IDLE) || w_lk_hit);
  assign w_accept = w_ready && bus.ifu_req_valid_i;

  assign w_beat_req  = rst_n && !r_wait
                    && (r_state == ICACHE_REFILL);
  assign w_beat_fire = w_beat_req && bus.mem_req_ready_i;
  assign w_beat_done = rst_n && r_wait
                    && (r_state == ICACHE_REFILL)
                    && bus.mem_resp_valid_i;
  assign w_last      = (r_beat == LAST_BEAT);
  assign w_fill_done = w_beat_done && w_last;
  assign w_flush_now = (r_state == ICACHE_IDLE) && r_flush;

  icache_data_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES)
  ) u_data (
    .clk       (clk),
    .i_we      (w_beat_done),
    .i_wr_idx  (w_idx),
    .i_wr_word (r_beat),
    .i_wr_data (bus.mem_resp_data_i),
    .i_rd_idx  (w_idx),
    .i_rd_word (w_off),
    .o_rd_data (w_rd_data)
  );

  assign bus.ifu_req_ready_o  = w_ready;
  assign bus.ifu_resp_valid_o = w_resp;
  assign bus.ifu_instr_o      = w_resp ? w_rd_data : r_instr;
  assign bus.mem_req_valid_o  = w_beat_req;
  assign bus.mem_addr_o       = w_beat_req
    ? {w_tag, w_idx, r_beat, 2'b00}
    : '0;

  // control FSM: accept, lookup, sequential refill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ICACHE_IDLE;
      r_addr  <= '0;
      r_beat  <= '0;
      r_wait  <= 1'b0;
      r_flush <= 1'b0;
      r_instr <= '0;
    end else begin
      r_flush <= bus.fence_i_i
              || (r_flush && (r_state != ICACHE_IDLE));
      if (w_resp) begin
        r_instr <= w_rd_data;
      end
      if (w_accept) begin
        r_addr <= bus.ifu_addr_i[ADDR_WIDTH-1:2];
      end
      unique case (r_state)
        ICACHE_IDLE: begin
          if (w_accept) begin
            r_state <= ICACHE_LOOKUP;
          end
        end
        ICACHE_LOOKUP: begin
          if (w_hit) begin
            r_state <= w_accept ? ICACHE_LOOKUP
                                : ICACHE_IDLE;
          end else begin
            r_state <= ICACHE_REFILL;
            r_beat  <= '0;
            r_wait  <= 1'b0;
          end
        end
        ICACHE_REFILL: begin
          if (w_beat_fire) begin
            r_wait <= 1'b1;
          end else if (w_beat_done) begin
            r_wait <= 1'b0;
            r_beat <= r_beat + 1'b1;
            if (w_last) begin
              r_state <= ICACHE_LOOKUP;
            end
          end
        end
        default: begin
          r_state <= ICACHE_IDLE;
        end
      endcase
    end
  end

  // valid bits: flush in IDLE, set when a line completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_flush_now) begin
      r_valid <= '0;
    end else if (w_fill_done) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // tag written together with the final beat
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_idx] <= w_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic        r_replay;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // hit/miss counters; the post-refill replay is not a hit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_replay   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_fill_done) begin
        r_replay <= 1'b1;
      end else if (w_lookup) begin
        r_replay <= 1'b0;
      end
      if (w_flush_now) begin
        r_hit_cnt  <= '0;
        r_miss_cnt <= '0;
      end else begin
        if (w_lk_hit && !r_replay) begin
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end
        if (w_lookup && !w_hit) begin
          r_miss_cnt <= r_miss_cnt + 32'd1;
        end
      end
    end
  end

  assign perf_hit_cnt_o  = r_hit_cnt;
  assign perf_miss_cnt_o = r_miss_cnt;
`else
  assign perf_hit_cnt_o  = '0;
  assign perf_miss_cnt_o = '0;
`endif

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the npc fetch port and pmem.
- Core side: latches fetch addresses with a valid/ready handshake and returns 32-bit instructions.
- Memory side: on a miss, refills one whole line from pmem as sequential single-word beats.
- Replaces the current direct wiring of npc to pmem.

Parameters:
ADDR_WIDTH, 32, fetch/memory byte-address width (from params.vh)
DATA_WIDTH, 32, instruction/word width (from params.vh)
LINE_WORDS, 4, words per line, power of two, >=2
NUM_LINES, 16, number of lines, power of two, >=2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ifu_req_valid_i  in  1  fetch request valid
ifu_req_ready_o  out  1  cache can accept request
ifu_addr_i  in  ADDR_WIDTH  fetch byte address
ifu_resp_valid_o  out  1  instruction valid, one-cycle pulse, no backpressure
ifu_instr_o  out  DATA_WIDTH  fetched instruction
fence_i_i  in  1  invalidate all lines (pulse)
mem_req_valid_o  out  1  refill beat request
mem_req_ready_i  in  1  pmem accepts beat request
mem_addr_o  out  ADDR_WIDTH  word-aligned beat address
mem_resp_valid_i  in  1  beat data valid
mem_resp_data_i  in  DATA_WIDTH  beat data
perf_hit_cnt_o  out  32  hit counter (optional feature)
perf_miss_cnt_o  out  32  miss counter (optional feature)

Behaviour:
- Address split, LSB first:
  - addr[1:0]: ignored.
  - word offset: log2(LINE_WORDS) bits.
  - index: log2(NUM_LINES) bits.
  - tag: remaining bits.
- Storage: tag/data arrays are flop-based with asynchronous read. Valid bits are separate flops.
- Reset (clk edge with rst_n=0):
  - All valid bits cleared; FSM to IDLE; flush-pending cleared.
  - All outputs 0, except ifu_req_ready_o, which is 0 during reset and 1 in the first IDLE cycle after.
  - Counters cleared.
- FSM states:
  - IDLE:
    - ready=1 unless flush pending.
    - A handshake latches addr, then -> LOOKUP.
  - LOOKUP, hit (valid && tag match):
    - ifu_resp_valid_o=1 and ifu_instr_o=word this cycle.
    - ready=1, so a new request may be accepted the same cycle and state stays LOOKUP.
    - Otherwise -> IDLE.
    - Hit latency is 1 cycle after accept; throughput is 1 per cycle.
  - LOOKUP, miss:
    - ready=0, resp_valid=0; -> REFILL with beat counter=0.
  - REFILL:
    - mem_req_valid_o=1 with mem_addr_o = {tag, index, beat, 2'b00}, held stable until mem_req_ready_i.
    - Then mem_req_valid_o=0 until mem_resp_valid_i; the beat is written to data[index][beat].
    - Only one beat outstanding; beats are issued in order 0..LINE_WORDS-1.
    - After the last beat: tag written, valid set, -> LOOKUP, which replays and hits.
  - Minimum miss-to-resp latency is 2 + 2*LINE_WORDS cycles when pmem is single-cycle.
- mem_resp_valid_i outside REFILL, or while a beat request is still pending: ignored.
- fence_i_i:
  - Sets flush-pending in any state.
  - Applied in the first IDLE cycle (all valid bits cleared); pending drops the next cycle.
  - While pending, ifu_req_ready_o=0 in IDLE and LOOKUP, though an in-flight LOOKUP hit still responds.
  - A refill in progress completes and responds first; its line is then invalidated.
- Synchronous reset mid-refill: aborts immediately, drops mem_req_valid_o, invalidates all lines. pmem shares rst_n, so no stale beats arrive.
- ifu_instr_o holds its last value when resp_valid=0. Benches must not check it.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined:
  - perf_hit_cnt_o increments on each LOOKUP hit.
  - perf_miss_cnt_o increments on each LOOKUP miss; the replay hit after a refill is not counted as a hit.
  - Both are 32-bit wrapping counters, cleared by reset and by fence_i_i application.
- Undefined: both ports tied to 0 and no counter flops.

Decomposition:
- params.vh gains:
  - ICACHE_LINE_WORDS and ICACHE_NUM_LINES defaults.
  - FSM state encodings ICACHE_IDLE/LOOKUP/REFILL (2-bit localparams).
- Sub-module icache_data_array: NUM_LINES x LINE_WORDS word storage, async read port, single write port (index, word, data, we).
- Tags, valid bits and FSM stay in icache_direct.

Test Plan:
- Cold miss:
  - Stimulus: after reset, req 0x8000_0000; pmem words 0x13,0x93,0x113,0x193; single-cycle pmem.
  - Required: 4 beats at 0x8000_0000..0x8000_000C, then resp instr 0x13 exactly 10 cycles after accept.
- Back-to-back hits: reqs 0x8000_0004, 0x8000_0008, 0x8000_000C on consecutive cycles -> resp each following cycle (0x93, 0x113, 0x193), no mem_req_valid_o.
- Conflict miss:
  - Stimulus: req 0x8000_0100 (same index, different tag), then 0x8000_0000.
  - Required: both refill; miss counter +2 with ICACHE_PERF_CNT_EN.
- pmem stall: mem_req_ready_i low for 3 cycles on beat 2 -> mem_addr_o held at 0x8000_0008 with valid high throughout; response delayed by exactly 3 cycles.
- fence_i:
  - Pulse fence_i_i mid-refill.
  - Required: refill completes and responds; ready=0 for 1 IDLE cycle; next req to the same address misses; counters read 0 then 1 miss.
- Reset mid-refill: rst_n=0 for 1 cycle during beat 1 -> mem_req_valid_o=0 next cycle, ready=1 after; the previously valid line now misses.
